ps2_frame_receiver: RTL and testbench
=====================================

// Module: ps2_frame_receiver
// PURPOSE
//  Deserialises PS/2 device-to-host frames (start, 8 data LSB-first, odd parity, stop)
//  from the raw ps2_clk/ps2_data pins into scan-code bytes. It feeds the keyboard state
//  decoder directly. scan_code_ready/scan_code connect to its scan_code_ready/scan_code_in.
//  Glitch filtering, parity/stop checking and frame timeout recovery are done here.
// PARAMETERS
//  FILTER_LEN      8       consecutive clk samples needed before filtered ps2_clk changes (>=2)
//  TIMEOUT_CYCLES  100000  clk cycles without a filtered falling edge mid-frame before abort (2 ms @ 50 MHz)
// PORTS
//  clk              in   1  system clock
//  reset            in   1  synchronous, active-high reset
//  ps2_clk          in   1  raw PS/2 clock pin, asynchronous
//  ps2_data         in   1  raw PS/2 data pin, asynchronous
//  scan_code_ready  out  1  one-cycle pulse: scan_code holds a new valid byte
//  scan_code        out  8  last valid received byte; held until the next valid frame
//  frame_error      out  1  one-cycle pulse: frame discarded
//  error_code       out  2  1=parity, 2=stop, 3=timeout; held until the next error
//  rx_busy          out  1  high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  - Interface: reset is synchronous, active-high; clock is clk.
//  - Reset values: scan_code_ready=0, scan_code=8'h00, frame_error=0, error_code=0, rx_busy=0.
//    Synchronisers, filter, timeout counter and shift register all clear. Filtered clk=1, state=IDLE.
//  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
//  - Filter: filtered clk takes the synchronised value only after FILTER_LEN consecutive equal samples.
//    Shorter pulses are ignored.
//  - Data sampling: data is sampled only in the cycle the filtered clk goes 1->0 ("fall").
//    The sampled value is the synchronised ps2_data of that cycle.
//  - FSM transitions on fall:
//    IDLE:   data=0 -> DATA, bit count=0. Data=1 -> stay IDLE, no error (spurious edge).
//    DATA:   shift the bit into [7] of the shift register, shifting right. After the 8th bit -> PARITY.
//    PARITY: store the bit -> STOP.
//    STOP:   -> IDLE. If ^{byte,parity}==1 and stop=1: scan_code=byte and scan_code_ready=1 for the next cycle.
//            Otherwise frame_error=1, with error_code=1 if parity is bad (checked first), else 2.
//  - Latency: ready/error pulse in the cycle after the STOP fall.
//    This is FILTER_LEN+3 cycles after the first clk edge that samples ps2_clk pin low, given stable pins.
//  - Timeout: the counter clears on every fall and in IDLE, and increments otherwise.
//    Reaching TIMEOUT_CYCLES outside IDLE -> IDLE, frame_error=1, error_code=3. The partial byte is discarded.
//  - A fall in the same cycle the timeout fires: the timeout wins and the fall is ignored.
//  - Pulses never overlap. At most one of scan_code_ready/frame_error is high, and only for 1 cycle per frame.
//  - Back-to-back frames (e.g. E0 then F0) need no idle gap beyond the PS/2 stop bit.
//  - Reset mid-frame: frame abandoned silently, no error pulse. Resumes with the next start bit.
//  - Counter width: $clog2(TIMEOUT_CYCLES+1). Bit counter: 3 bits. No wrap-around is possible.
//  - Host-to-device transmission is not supported. The pins are inputs only.
// TESTING
//  1. Frame 0x1C, parity 0, stop 1, bit period 80 us -> one scan_code_ready pulse, scan_code=8'h1C, no frame_error.
//  2. Frame 0x1C with parity 1 -> frame_error pulse, error_code=1, no ready, scan_code unchanged.
//  3. Frame 0xF0, parity 1, stop 0 -> frame_error pulse, error_code=2.
//  4. Start + 5 data bits, then pins idle for TIMEOUT_CYCLES -> frame_error, error_code=3, rx_busy=0.
//     A following 0xF0 frame then gives ready with scan_code=8'hF0.
//  5. A ps2_clk low glitch of FILTER_LEN-1 cycles, idle and mid-frame -> no state change. Next frame 0x75 is received correctly.
//  6. Reset asserted after 4 data bits -> all outputs reset values, no pulses. The next frame 0xE0 (parity 0) -> ready with 8'hE0.

Source files
------------

// File: rtl/ps2_frame_receiver_if.sv
// PS/2 receiver bus: raw device pins in, decoded scan-code and error reporting out.
//   ps2_clk, ps2_data  raw PS/2 pins (asynchronous to clk)
//   scan_code_ready    one-cycle pulse, scan_code holds a new byte
//   scan_code          last valid byte, held until the next valid frame
//   frame_error        one-cycle pulse, frame discarded
//   error_code         1=parity, 2=stop, 3=timeout; held until the next error
//   rx_busy            frame in progress
// master: the receiver. slave: the pin driver / scan-code consumer.
interface ps2_frame_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       scan_code_ready;
    logic [7:0] scan_code;
    logic       frame_error;
    logic [1:0] error_code;
    logic       rx_busy;

    modport master (
        input  ps2_clk, ps2_data,
        output scan_code_ready, scan_code, frame_error, error_code, rx_busy
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  scan_code_ready, scan_code, frame_error, error_code, rx_busy
    );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver (start, 8 data LSB-first, odd parity, stop).
// Synchronises and glitch-filters the raw pins, deserialises frames on filtered
// ps2_clk falling edges, checks parity/stop and aborts stalled frames.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    ps2_frame_receiver_if.master (pins in, scan code / error status out)
module ps2_frame_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    ps2_frame_receiver_if.master   bus
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_next;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt, filt_d;
    logic [FW-1:0] fcnt;
    logic          fall;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          parity_bit;
    logic          parity_ok;

    logic          ready_next, error_next, load_scan;
    logic [1:0]    ecode_next;
    logic          ready_q, error_q;
    logic [7:0]    scan_q;
    logic [1:0]    ecode_q;
    logic          busy;

    // Two-flop synchronisers for both pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            clk_s1  <= bus.ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= bus.ps2_data;
            data_s2 <= data_s1;
        end
    end

    // fcnt counts consecutive samples that disagree with the filtered clock;
    // once FILTER_LEN of them have been seen the filtered clock follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt   <= '0;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            filt_d <= filt;
            if (fcnt == FW'(FILTER_LEN)) begin
                filt <= ~filt;
                fcnt <= '0;
            end else if (clk_s2 != filt) begin
                fcnt <= fcnt + 1'b1;
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign fall    = filt_d & ~filt;
    assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset || state == IDLE || fall || timeout)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM: next state (timeout takes priority over a coincident fall)
    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_s2) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Shift register, bit counter and parity capture
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
        end else if (fall && !timeout) begin
            case (state)
                IDLE:    bit_cnt <= '0;
                DATA: begin
                    shreg   <= {data_s2, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY:  parity_bit <= data_s2;
                default: ;
            endcase
        end
    end

    assign parity_ok = ^{shreg, parity_bit};

    // FSM: outputs (pulse values registered below for the following cycle)
    always_comb begin
        ready_next = 1'b0;
        error_next = 1'b0;
        load_scan  = 1'b0;
        ecode_next = ecode_q;
        busy       = (state != IDLE);
        if (timeout) begin
            error_next = 1'b1;
            ecode_next = 2'd3;
        end else if (fall && state == STOP) begin
            if (!parity_ok) begin
                error_next = 1'b1;
                ecode_next = 2'd1;
            end else if (!data_s2) begin
                error_next = 1'b1;
                ecode_next = 2'd2;
            end else begin
                ready_next = 1'b1;
                load_scan  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            ecode_q <= '0;
            scan_q  <= '0;
        end else begin
            ready_q <= ready_next;
            error_q <= error_next;
            ecode_q <= ecode_next;
            if (load_scan)
                scan_q <= shreg;
        end
    end

    assign bus.scan_code_ready = ready_q;
    assign bus.scan_code       = scan_q;
    assign bus.frame_error     = error_q;
    assign bus.error_code      = ecode_q;
    assign bus.rx_busy         = busy;
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: directed PS/2 frames on the pins, an event-queue
// model predicting pulse cycles and held values, compared on every falling clk edge.
module tb_ps2_frame_receiver;
    localparam int unsigned FL = 8;
    localparam int unsigned TO = 300;
    localparam int unsigned H  = 20;   // half PS/2 bit period in clk cycles

    logic clk = 1'b0;
    logic reset = 1'b1;

    ps2_frame_receiver_if bus();

    ps2_frame_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned edge_count = 0;
    always @(posedge clk) edge_count <= edge_count + 1;

    typedef struct {
        int unsigned at;
        logic        is_err;
        logic [7:0]  val;
        logic [1:0]  code;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] exp_scan  = 8'h00;
    logic [1:0] exp_ecode = 2'd0;
    logic       exp_rdy, exp_err;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_count);
        end
    endtask

    // Model: the pin edge that starts a clk-low phase is reached by the first
    // posedge after it; a pulse follows FILTER_LEN+3 edges later.
    always @(negedge clk) begin
        if (!reset) begin
            exp_rdy = 1'b0;
            exp_err = 1'b0;
            if (evq.size() > 0 && evq[0].at == edge_count) begin
                if (evq[0].is_err) begin
                    exp_err   = 1'b1;
                    exp_ecode = evq[0].code;
                end else begin
                    exp_rdy  = 1'b1;
                    exp_scan = evq[0].val;
                end
                void'(evq.pop_front());
            end
            check("scan_code_ready", 8'(bus.scan_code_ready), 8'(exp_rdy));
            check("frame_error", 8'(bus.frame_error), 8'(exp_err));
            check("scan_code", bus.scan_code, exp_scan);
            check("error_code", 8'(bus.error_code), 8'(exp_ecode));
        end
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // n = edge count at the moment the pin goes low
    task automatic fall_bit(input logic b, output int unsigned n);
        bus.ps2_data = b;
        wait_cycles(H);
        bus.ps2_clk = 1'b0;
        n = edge_count;
    endtask

    task automatic release_clk();
        wait_cycles(H);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic glitch();
        wait_cycles(H / 2);
        bus.ps2_clk = 1'b0;
        wait_cycles(FL - 1);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic p, input logic s,
                                input int unsigned n);
        ev_t e;
        e.at  = n + FL + 4;
        e.val = b;
        if (($countones({b, p}) % 2) == 1 && s) begin
            e.is_err = 1'b0;
            e.code   = 2'd0;
        end else begin
            e.is_err = 1'b1;
            e.code   = (($countones({b, p}) % 2) == 1) ? 2'd2 : 2'd1;
        end
        evq.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                              input int glitch_after);
        logic [10:0] bits;
        int unsigned n;
        bits = {s, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            fall_bit(bits[i], n);
            if (i == 10) expect_frame(b, p, s, n);
            release_clk();
            if (i == glitch_after) glitch();
        end
        bus.ps2_data = 1'b1;
    endtask

    // Start bit plus the first nbits data bits of b; returns the last fall edge.
    task automatic send_partial(input logic [7:0] b, input int unsigned nbits,
                                output int unsigned n);
        fall_bit(1'b0, n);
        release_clk();
        for (int unsigned i = 0; i < nbits; i++) begin
            fall_bit(b[i], n);
            release_clk();
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic check_reset_values();
        check("rst scan_code_ready", 8'(bus.scan_code_ready), 8'd0);
        check("rst scan_code", bus.scan_code, 8'h00);
        check("rst frame_error", 8'(bus.frame_error), 8'd0);
        check("rst error_code", 8'(bus.error_code), 8'd0);
        check("rst rx_busy", 8'(bus.rx_busy), 8'd0);
    endtask

    initial begin
        int unsigned n;
        ev_t e;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b1;
        wait_cycles(4);
        check_reset_values();
        reset = 1'b0;
        wait_cycles(30);

        // Valid 0x1C
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        wait_cycles(30);
        check("t1 scan_code", bus.scan_code, 8'h1C);
        check("t1 error_code", 8'(bus.error_code), 8'd0);
        check("t1 rx_busy", 8'(bus.rx_busy), 8'd0);

        // Bad parity
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        wait_cycles(30);
        check("t2 scan_code", bus.scan_code, 8'h1C);
        check("t2 error_code", 8'(bus.error_code), 8'd1);

        // Bad stop bit
        send_frame(8'hF0, 1'b1, 1'b0, -1);
        wait_cycles(30);
        check("t3 error_code", 8'(bus.error_code), 8'd2);

        // Spurious idle fall with data high
        fall_bit(1'b1, n);
        release_clk();
        wait_cycles(30);
        check("spurious rx_busy", 8'(bus.rx_busy), 8'd0);
        check("spurious error_code", 8'(bus.error_code), 8'd2);

        // Timeout after start + 5 data bits
        send_partial(8'hF0, 5, n);
        check("t4 mid rx_busy", 8'(bus.rx_busy), 8'd1);
        e.at = n + FL + 5 + TO;
        e.is_err = 1'b1;
        e.val = 8'h00;
        e.code = 2'd3;
        evq.push_back(e);
        wait_cycles(TO + FL + 40);
        check("t4 rx_busy", 8'(bus.rx_busy), 8'd0);
        check("t4 error_code", 8'(bus.error_code), 8'd3);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        wait_cycles(30);
        check("t4 scan_code", bus.scan_code, 8'hF0);

        // Glitches idle and mid-frame
        glitch();
        wait_cycles(30);
        check("t5 idle rx_busy", 8'(bus.rx_busy), 8'd0);
        send_frame(8'h75, 1'b0, 1'b1, 3);
        wait_cycles(30);
        check("t5 scan_code", bus.scan_code, 8'h75);

        // Back-to-back E0 F0
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        wait_cycles(30);
        check("b2b scan_code", bus.scan_code, 8'hF0);

        // Reset after 4 data bits
        send_partial(8'hE0, 4, n);
        check("t6 mid rx_busy", 8'(bus.rx_busy), 8'd1);
        reset = 1'b1;
        evq.delete();
        exp_scan  = 8'h00;
        exp_ecode = 2'd0;
        wait_cycles(3);
        check_reset_values();
        reset = 1'b0;
        wait_cycles(30);
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        wait_cycles(30);
        check("t6 scan_code", bus.scan_code, 8'hE0);
        check("t6 error_code", 8'(bus.error_code), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
